// File: rtl/beam_weight_pkg.sv
// Shared constants, FSM state type and the cos/sin coefficient table for beam_weight_loader.
// Optional feature macro used by the top: BWL_READBACK_EN.
package beam_weight_pkg;

    localparam int W          = 5;
    localparam int PHASE_BITS = 4;
    localparam int FRAME_LEN  = 8;
    localparam int AMP        = (1 << (W - 1)) - 1;
    localparam int CNT_W      = $clog2(FRAME_LEN);

    localparam logic [PHASE_BITS-1:0] QUARTER = PHASE_BITS'(1 << (PHASE_BITS - 2));

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOOKUP = 2'd1,
        WRITE  = 2'd2,
        PEND   = 2'd3
    } bwl_state_t;

    // Quarter-wave sine in Q16 for 16 phases; the other three quadrants fold onto it.
    function automatic int quarter_q16(input int n);
        case (n)
            0:       return 0;
            1:       return 25080;
            2:       return 46341;
            3:       return 60547;
            default: return 65536;
        endcase
    endfunction

    function automatic logic signed [W-1:0] trig_sin(input logic [PHASE_BITS-1:0] k);
        int idx;
        int mag;
        idx = int'(k[PHASE_BITS-3:0]);
        if (k[PHASE_BITS-2])
            idx = int'(QUARTER) - idx;
        mag = (AMP * quarter_q16(idx) + 32768) >>> 16;
        if (mag > AMP)
            mag = AMP;
        return k[PHASE_BITS-1] ? W'(-mag) : W'(mag);
    endfunction

    function automatic logic signed [W-1:0] trig_cos(input logic [PHASE_BITS-1:0] k);
        logic [PHASE_BITS-1:0] kk;
        kk = k + QUARTER;
        return trig_sin(kk);
    endfunction

    localparam logic signed [W-1:0] RST_COS = W'(AMP);
    localparam logic signed [W-1:0] RST_SIN = '0;

endpackage

// File: rtl/beam_weight_loader_rom.sv
// bwl_trig_rom: registered cos/sin lookup of one phase code.
module bwl_trig_rom
    import beam_weight_pkg::*;
(
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_rd_en,
    input  logic [PHASE_BITS-1:0] i_phase,
    output logic signed [W-1:0]   o_cos,
    output logic signed [W-1:0]   o_sin
);

    logic signed [W-1:0] r_cos;
    logic signed [W-1:0] r_sin;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cos <= RST_COS;
            r_sin <= RST_SIN;
        end else if (i_rd_en) begin
            r_cos <= trig_cos(i_phase);
            r_sin <= trig_sin(i_phase);
        end
    end

    assign o_cos = r_cos;
    assign o_sin = r_sin;

endmodule

// File: rtl/beam_weight_loader.sv
// Two-beam phase-shifter weight loader: phase commands fill a shadow bank, commits copy it on a frame tick.
// Define BWL_READBACK_EN to add the rb_sel/rb_data shadow readback port.
module beam_weight_loader
    import beam_weight_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_beam,
    input  logic [PHASE_BITS-1:0] cmd_phase,
    input  logic                  cmd_commit,
    output logic signed [W-1:0]   w_cos_1,
    output logic signed [W-1:0]   w_sin_1,
    output logic signed [W-1:0]   w_cos_2,
    output logic signed [W-1:0]   w_sin_2,
    output logic                  frame_tick,
    output logic                  update_done
`ifdef BWL_READBACK_EN
    ,
    input  logic [1:0]            rb_sel,
    output logic signed [W-1:0]   rb_data
`endif
);

    bwl_state_t            r_state;
    bwl_state_t            w_next;
    logic                  r_ready;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_tick;
    logic                  r_beam;
    logic [PHASE_BITS-1:0] r_phase;
    logic                  r_commit;
    logic                  r_pend_armed;
    logic                  r_done;
    logic signed [W-1:0]   r_shadow [4];
    logic signed [W-1:0]   r_active [4];
    logic signed [W-1:0]   w_rom_cos;
    logic signed [W-1:0]   w_rom_sin;
    logic                  w_accept;
    logic                  w_load;

    assign w_accept = cmd_valid & r_ready;
    // The tick seen in the first PEND cycle is ignored, so a commit never lands mid-frame.
    assign w_load   = (r_state == PEND) & r_pend_armed & r_tick;

    bwl_trig_rom u_rom (
        .i_clk   (clock),
        .i_rst_n (reset_n),
        .i_rd_en (r_state == LOOKUP),
        .i_phase (r_phase),
        .o_cos   (w_rom_cos),
        .o_sin   (w_rom_sin)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else begin
            r_cnt  <= (r_cnt == CNT_W'(FRAME_LEN - 1)) ? '0 : r_cnt + 1'b1;
            r_tick <= (r_cnt == CNT_W'(FRAME_LEN - 2));
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next = LOOKUP;
            LOOKUP:  w_next = WRITE;
            WRITE:   w_next = r_commit ? PEND : IDLE;
            PEND:    if (w_load) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= IDLE;
            r_ready      <= 1'b0;
            r_beam       <= 1'b0;
            r_phase      <= '0;
            r_commit     <= 1'b0;
            r_pend_armed <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_state      <= w_next;
            r_ready      <= (w_next == IDLE);
            r_pend_armed <= (r_state == PEND) && (w_next == PEND);
            r_done       <= w_load;
            if (w_accept) begin
                r_beam   <= cmd_beam;
                r_phase  <= cmd_phase;
                r_commit <= cmd_commit;
            end
        end
    end

    // Bank word order: 0 cos1, 1 sin1, 2 cos2, 3 sin2.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 4; i++) begin
                r_shadow[i] <= i[0] ? RST_SIN : RST_COS;
                r_active[i] <= i[0] ? RST_SIN : RST_COS;
            end
        end else begin
            if (r_state == WRITE) begin
                r_shadow[{r_beam, 1'b0}] <= w_rom_cos;
                r_shadow[{r_beam, 1'b1}] <= w_rom_sin;
            end
            if (w_load)
                r_active <= r_shadow;
        end
    end

`ifdef BWL_READBACK_EN
    logic signed [W-1:0] r_rb_data;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            r_rb_data <= '0;
        else
            r_rb_data <= r_shadow[rb_sel];
    end

    assign rb_data = r_rb_data;
`endif

    assign cmd_ready   = r_ready;
    assign frame_tick  = r_tick;
    assign update_done = r_done;
    assign w_cos_1     = r_active[0];
    assign w_sin_1     = r_active[1];
    assign w_cos_2     = r_active[2];
    assign w_sin_2     = r_active[3];

endmodule

// File: tb/tb_beam_weight_loader.sv
// Self-checking bench for beam_weight_loader: random phase commands against a frame-level reference model.
module tb_beam_weight_loader;

    logic              clock = 1'b0;
    logic              reset_n = 1'b0;
    logic              cmd_valid = 1'b0;
    logic              cmd_beam = 1'b0;
    logic [3:0]        cmd_phase = '0;
    logic              cmd_commit = 1'b0;
    logic              cmd_ready;
    logic signed [4:0] w_cos_1, w_sin_1, w_cos_2, w_sin_2;
    logic              frame_tick, update_done;
`ifdef BWL_READBACK_EN
    logic [1:0]        rb_sel = '0;
    logic signed [4:0] rb_data;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    int cyc;
    int sh[4];
    int ac[4];

    beam_weight_loader dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_beam    (cmd_beam),
        .cmd_phase   (cmd_phase),
        .cmd_commit  (cmd_commit),
        .w_cos_1     (w_cos_1),
        .w_sin_1     (w_sin_1),
        .w_cos_2     (w_cos_2),
        .w_sin_2     (w_sin_2),
        .frame_tick  (frame_tick),
        .update_done (update_done)
`ifdef BWL_READBACK_EN
        ,
        .rb_sel      (rb_sel),
        .rb_data     (rb_data)
`endif
    );

    always #5 clock = ~clock;

    // Cycle index since reset release; frame position is cyc % 8.
    always @(posedge clock or negedge reset_n)
        if (!reset_n) cyc <= 0;
        else          cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1);
    end

    function automatic int clamp15(input int v);
        return (v > 15) ? 15 : (v < -15) ? -15 : v;
    endfunction

    function automatic int ref_cos(input int k);
        real v;
        v = 15.0 * $cos(6.283185307179586 * real'(k) / 16.0);
        return clamp15(int'(v));
    endfunction

    function automatic int ref_sin(input int k);
        real v;
        v = 15.0 * $sin(6.283185307179586 * real'(k) / 16.0);
        return clamp15(int'(v));
    endfunction

    // Commit accepted at the end of cycle a: PEND entered at a+3, loads on the first tick cycle after that.
    function automatic int commit_cycle(input int a);
        int t;
        t = a + 4;
        while (t % 8 != 7) t++;
        return t;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 4; i++) begin
            sh[i] = (i % 2 == 0) ? 15 : 0;
            ac[i] = sh[i];
        end
    endfunction

    function automatic void model_commit();
        for (int i = 0; i < 4; i++) ac[i] = sh[i];
    endfunction

    task automatic align_to(input int pos);
        int n;
        n = 0;
        while ((cyc % 8 != pos || cmd_ready !== 1'b1) && n < 64) begin
            @(negedge clock);
            n++;
        end
    endtask

    task automatic send(input int beam, input int ph, input bit commit, output int acc);
        int n;
        n = 0;
        cmd_valid  = 1'b1;
        cmd_beam   = beam[0];
        cmd_phase  = 4'(ph);
        cmd_commit = commit;
        while (cmd_ready !== 1'b1 && n < 64) begin
            @(negedge clock);
            n++;
        end
        if (n >= 64) begin
            n_cmp++; n_bad++;
            $display("FAIL send_timeout: cmd_ready=%b required 1", cmd_ready);
        end
        acc = cyc;
        sh[beam*2]   = ref_cos(ph);
        sh[beam*2+1] = ref_sin(ph);
        @(negedge clock);
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        model_reset();
        repeat (3) @(negedge clock);
        n_cmp++; if (w_cos_1 !== 5'sd15 || w_cos_2 !== 5'sd15) begin n_bad++;
            $display("FAIL rst_cos: got %0d/%0d required 15/15", w_cos_1, w_cos_2); end
        n_cmp++; if (w_sin_1 !== 5'sd0 || w_sin_2 !== 5'sd0) begin n_bad++;
            $display("FAIL rst_sin: got %0d/%0d required 0/0", w_sin_1, w_sin_2); end
        n_cmp++; if ({cmd_ready, frame_tick, update_done} !== 3'b000) begin n_bad++;
            $display("FAIL rst_ctl: ready/tick/done=%b required 000", {cmd_ready, frame_tick, update_done}); end
        reset_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            n_cmp++; if (frame_tick !== (i % 8 == 7)) begin n_bad++;
                $display("FAIL rst_tick_c%0d: got %b required %b", i, frame_tick, (i % 8 == 7)); end
            if (i == 1) begin
                n_cmp++; if (cmd_ready !== 1'b1) begin n_bad++;
                    $display("FAIL rst_ready: got %b required 1", cmd_ready); end
            end
            @(negedge clock);
        end
    endtask

    task automatic test_commit_single();
        int a, t;
        align_to(2);
        send(0, 4, 1'b1, a);
        t = commit_cycle(a);
        n_cmp++; if (cmd_ready !== 1'b0) begin n_bad++;
            $display("FAIL t2_ready_low: got %b required 0", cmd_ready); end
        repeat (t - cyc) @(negedge clock);
        n_cmp++; if (frame_tick !== 1'b1 || w_cos_1 !== 5'sd15 || update_done !== 1'b0) begin n_bad++;
            $display("FAIL t2_pre: tick=%b cos1=%0d done=%b required 1/15/0", frame_tick, w_cos_1, update_done); end
        @(negedge clock);
        model_commit();
        n_cmp++; if (w_cos_1 !== 5'sd0 || w_sin_1 !== 5'sd15) begin n_bad++;
            $display("FAIL t2_beam1: got (%0d,%0d) required (0,15)", w_cos_1, w_sin_1); end
        n_cmp++; if (update_done !== 1'b1) begin n_bad++;
            $display("FAIL t2_done: got %b required 1", update_done); end
        n_cmp++; if (w_cos_2 !== 5'sd15 || w_sin_2 !== 5'sd0) begin n_bad++;
            $display("FAIL t2_beam2: got (%0d,%0d) required (15,0)", w_cos_2, w_sin_2); end
        @(negedge clock);
        n_cmp++; if (update_done !== 1'b0) begin n_bad++;
            $display("FAIL t2_done_pulse: got %b required 0", update_done); end
    endtask

    task automatic test_accumulate();
        int a, t;
        send(1, 8, 1'b0, a);
        repeat (a + 3 - cyc) @(negedge clock);
        n_cmp++; if (w_cos_2 !== 5'sd15 || cmd_ready !== 1'b1) begin n_bad++;
            $display("FAIL t3_nocommit: cos2=%0d ready=%b required 15/1", w_cos_2, cmd_ready); end
        send(0, 2, 1'b1, a);
        t = commit_cycle(a);
        repeat (t - cyc) @(negedge clock);
        n_cmp++; if (w_cos_2 !== 5'sd15 || w_cos_1 !== 5'sd0) begin n_bad++;
            $display("FAIL t3_pre: cos2=%0d cos1=%0d required 15/0", w_cos_2, w_cos_1); end
        @(negedge clock);
        model_commit();
        n_cmp++; if (w_cos_2 !== -5'sd15 || w_sin_2 !== 5'sd0) begin n_bad++;
            $display("FAIL t3_beam2: got (%0d,%0d) required (-15,0)", w_cos_2, w_sin_2); end
        n_cmp++; if (w_cos_1 !== 5'sd11 || w_sin_1 !== 5'sd11) begin n_bad++;
            $display("FAIL t3_beam1: got (%0d,%0d) required (11,11)", w_cos_1, w_sin_1); end
    endtask

    task automatic test_pend_on_tick();
        int a, t, ph;
        ph = int'($urandom_range(1, 15));
        align_to(4);
        send(1, ph, 1'b1, a);
        t = commit_cycle(a);
        repeat (a + 3 - cyc) @(negedge clock);
        n_cmp++; if (frame_tick !== 1'b1 || w_cos_2 !== 5'(ac[2]) || w_sin_2 !== 5'(ac[3])) begin n_bad++;
            $display("FAIL t4_entry_tick: tick=%b w2=(%0d,%0d) required 1 (%0d,%0d)", frame_tick, w_cos_2, w_sin_2, ac[2], ac[3]); end
        @(negedge clock);
        n_cmp++; if (update_done !== 1'b0 || w_cos_2 !== 5'(ac[2])) begin n_bad++;
            $display("FAIL t4_skipped: done=%b cos2=%0d required 0/%0d", update_done, w_cos_2, ac[2]); end
        n_cmp++; if (t - (a + 3) !== 8) begin n_bad++;
            $display("FAIL t4_wait: model wait %0d required 8", t - (a + 3)); end
        repeat (t - cyc) @(negedge clock);
        n_cmp++; if (w_cos_2 !== 5'(ac[2]) || update_done !== 1'b0) begin n_bad++;
            $display("FAIL t4_pre: cos2=%0d done=%b required %0d/0", w_cos_2, update_done, ac[2]); end
        @(negedge clock);
        model_commit();
        n_cmp++; if (w_cos_2 !== 5'(ac[2]) || w_sin_2 !== 5'(ac[3]) || update_done !== 1'b1) begin n_bad++;
            $display("FAIL t4_post: w2=(%0d,%0d) done=%b required (%0d,%0d) 1", w_cos_2, w_sin_2, update_done, ac[2], ac[3]); end
    endtask

    task automatic test_back_to_back();
        int a, t, p1, p2, p3;
        p1 = int'($urandom_range(0, 15));
        p2 = int'($urandom_range(0, 15));
        p3 = int'($urandom_range(0, 15));
        send(1, p1, 1'b0, a);
        send(1, p2, 1'b0, a);
        send(0, p3, 1'b1, a);
        t = commit_cycle(a);
        repeat (t + 1 - cyc) @(negedge clock);
        n_cmp++; if (w_cos_2 !== 5'(ref_cos(p2)) || w_sin_2 !== 5'(ref_sin(p2))) begin n_bad++;
            $display("FAIL b2b_last_wins: got (%0d,%0d) required (%0d,%0d) k=%0d", w_cos_2, w_sin_2, ref_cos(p2), ref_sin(p2), p2); end
        n_cmp++; if (w_cos_1 !== 5'(ref_cos(p3)) || w_sin_1 !== 5'(ref_sin(p3))) begin n_bad++;
            $display("FAIL b2b_beam1: got (%0d,%0d) required (%0d,%0d) k=%0d", w_cos_1, w_sin_1, ref_cos(p3), ref_sin(p3), p3); end
        model_commit();
    endtask

    task automatic test_random();
        int a, t, beam, ph, gap;
        bit cm;
        for (int it = 0; it < 12; it++) begin
            beam = int'($urandom_range(0, 1));
            ph   = int'($urandom_range(0, 15));
            cm   = bit'($urandom_range(0, 1));
            gap  = int'($urandom_range(0, 5));
            repeat (gap) @(negedge clock);
            send(beam, ph, cm, a);
            if (cm) begin
                t = commit_cycle(a);
                repeat (t - cyc) @(negedge clock);
                n_cmp++; if (w_cos_1 !== 5'(ac[0]) || w_sin_1 !== 5'(ac[1]) || w_cos_2 !== 5'(ac[2]) || w_sin_2 !== 5'(ac[3]) || cmd_ready !== 1'b0) begin n_bad++;
                    $display("FAIL rnd_pre_%0d: (%0d,%0d,%0d,%0d) ready=%b required (%0d,%0d,%0d,%0d) 0", it, w_cos_1, w_sin_1, w_cos_2, w_sin_2, cmd_ready, ac[0], ac[1], ac[2], ac[3]); end
                @(negedge clock);
                model_commit();
                n_cmp++; if (w_cos_1 !== 5'(ac[0]) || w_sin_1 !== 5'(ac[1]) || w_cos_2 !== 5'(ac[2]) || w_sin_2 !== 5'(ac[3]) || update_done !== 1'b1) begin n_bad++;
                    $display("FAIL rnd_post_%0d: (%0d,%0d,%0d,%0d) done=%b required (%0d,%0d,%0d,%0d) 1", it, w_cos_1, w_sin_1, w_cos_2, w_sin_2, update_done, ac[0], ac[1], ac[2], ac[3]); end
            end else begin
                repeat (a + 3 - cyc) @(negedge clock);
                n_cmp++; if (w_cos_1 !== 5'(ac[0]) || w_sin_2 !== 5'(ac[3]) || cmd_ready !== 1'b1) begin n_bad++;
                    $display("FAIL rnd_hold_%0d: cos1=%0d sin2=%0d ready=%b required %0d/%0d/1", it, w_cos_1, w_sin_2, cmd_ready, ac[0], ac[3]); end
            end
        end
    endtask

    task automatic test_reset_in_pend();
        int a;
        align_to(4);
        send(0, 12, 1'b1, a);
        repeat (a + 5 - cyc) @(negedge clock);
        reset_n = 1'b0;
        model_reset();
        @(negedge clock);
        n_cmp++; if (w_cos_1 !== 5'sd15 || w_sin_1 !== 5'sd0 || cmd_ready !== 1'b0) begin n_bad++;
            $display("FAIL rip_in_reset: (%0d,%0d) ready=%b required (15,0) 0", w_cos_1, w_sin_1, cmd_ready); end
        reset_n = 1'b1;
        for (int i = 0; i < 14; i++) begin
            n_cmp++; if (update_done !== 1'b0 || w_cos_1 !== 5'sd15 || w_sin_1 !== 5'sd0) begin n_bad++;
                $display("FAIL rip_c%0d: done=%b (%0d,%0d) required 0 (15,0)", i, update_done, w_cos_1, w_sin_1); end
            if (i == 1) begin
                n_cmp++; if (cmd_ready !== 1'b1) begin n_bad++;
                    $display("FAIL rip_ready: got %b required 1", cmd_ready); end
            end
            @(negedge clock);
        end
    endtask

`ifdef BWL_READBACK_EN
    task automatic test_readback();
        int a;
        send(1, 12, 1'b0, a);
        repeat (a + 3 - cyc) @(negedge clock);
        rb_sel = 2'd3;
        @(negedge clock);
        n_cmp++; if (rb_data !== -5'sd15 || w_sin_2 !== 5'(ac[3])) begin n_bad++;
            $display("FAIL rb_sin2: rb=%0d sin2=%0d required -15/%0d", rb_data, w_sin_2, ac[3]); end
        rb_sel = 2'd0;
        @(negedge clock);
        n_cmp++; if (rb_data !== 5'(sh[0])) begin n_bad++;
            $display("FAIL rb_cos1: rb=%0d required %0d", rb_data, sh[0]); end
    endtask
`endif

    initial begin
        test_reset();
        test_commit_single();
        test_accumulate();
        test_pend_on_tick();
        test_back_to_back();
        test_random();
        test_reset_in_pend();
`ifdef BWL_READBACK_EN
        test_readback();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
